// File: rtl/muldiv_rs_scheduler.sv
// Reservation-station bank and single-issue scheduler for the MUL/DIV functional unit.
// Optional DIVZERO_TRAP_EN: DIV by zero bypasses the FU and reports ResErr with an all-ones result.
module muldiv_rs_scheduler #(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned NUM_RS   = 2,
  parameter int unsigned TAG_W    = 2,
  parameter int unsigned TAG_BASE = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              IssueValid,
  input  logic [2:0]        IssueOp,
  input  logic [DATA_W-1:0] IssueVj,
  input  logic [DATA_W-1:0] IssueVk,
  input  logic [TAG_W-1:0]  IssueQj,
  input  logic [TAG_W-1:0]  IssueQk,
  input  logic              IssueQjValid,
  input  logic              IssueQkValid,
  output logic              IssueReady,
  output logic [TAG_W-1:0]  IssueTag,
  output logic              IssueIllegal,
  input  logic              CdbValid,
  input  logic [TAG_W-1:0]  CdbTag,
  input  logic [DATA_W-1:0] CdbData,
  output logic              FuEn,
  output logic [DATA_W-1:0] FuRx,
  output logic [DATA_W-1:0] FuRy,
  output logic [2:0]        FuOp,
  output logic [TAG_W-1:0]  FuLabel,
  input  logic              FuDone,
  input  logic [DATA_W-1:0] FuOut,
  input  logic [TAG_W-1:0]  FuLabelOut,
  output logic              ResValid,
  output logic [TAG_W-1:0]  ResTag,
  output logic [DATA_W-1:0] ResData,
`ifdef DIVZERO_TRAP_EN
  output logic              ResErr,
`endif
  input  logic              ResAck
);

  localparam int unsigned IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESULT} state_e;

  state_e             state_q, state_d;
  logic [NUM_RS-1:0]  busy_q, busy_d, disp_q, disp_d, pj_q, pj_d, pk_q, pk_d;
  logic [DATA_W-1:0]  vj_q [NUM_RS];
  logic [DATA_W-1:0]  vj_d [NUM_RS];
  logic [DATA_W-1:0]  vk_q [NUM_RS];
  logic [DATA_W-1:0]  vk_d [NUM_RS];
  logic [TAG_W-1:0]   qj_q [NUM_RS];
  logic [TAG_W-1:0]   qj_d [NUM_RS];
  logic [TAG_W-1:0]   qk_q [NUM_RS];
  logic [TAG_W-1:0]   qk_d [NUM_RS];
  logic [2:0]         op_q [NUM_RS];
  logic [2:0]         op_d [NUM_RS];
  logic [IDX_W-1:0]   cur_q, cur_d, last_q, last_d;
  logic               ready_q, ready_d;
  logic               fu_en_q, fu_en_d;
  logic [DATA_W-1:0]  fu_rx_q, fu_rx_d, fu_ry_q, fu_ry_d;
  logic [2:0]         fu_op_q, fu_op_d;
  logic [TAG_W-1:0]   fu_label_q, fu_label_d;
  logic               res_valid_q, res_valid_d;
  logic [TAG_W-1:0]   res_tag_q, res_tag_d;
  logic [DATA_W-1:0]  res_data_q, res_data_d;
`ifdef DIVZERO_TRAP_EN
  logic               res_err_q, res_err_d;
`endif

  logic               free_found, pick_found, op_legal, accept;
  logic [IDX_W-1:0]   free_idx, pick_idx;
  logic [IDX_W:0]     rr_c;
  logic [NUM_RS-1:0]  rdy;

  assign op_legal     = (IssueOp == OP_MUL) || (IssueOp == OP_DIV);
  assign accept       = IssueValid && ready_q && free_found && op_legal;
  assign IssueIllegal = IssueValid && ready_q && !op_legal;
  assign IssueReady   = ready_q;
  assign IssueTag     = ready_q ? (TAG_W'(TAG_BASE) + TAG_W'(free_idx)) : '0;
  assign rdy          = busy_q & ~pj_q & ~pk_q & ~disp_q;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      if (!free_found && !busy_q[IDX_W'(i)]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Round-robin search begins one past the last dispatched station.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    rr_c       = '0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      rr_c = {1'b0, last_q} + (IDX_W+1)'(1) + (IDX_W+1)'(i);
      if (rr_c >= (IDX_W+1)'(NUM_RS)) rr_c = rr_c - (IDX_W+1)'(NUM_RS);
      if (!pick_found && rdy[rr_c[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = rr_c[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d = busy_q;  disp_d = disp_q;  pj_d = pj_q;  pk_d = pk_q;
    vj_d = vj_q;  vk_d = vk_q;  qj_d = qj_q;  qk_d = qk_q;  op_d = op_q;
    cur_d = cur_q;  last_d = last_q;
    fu_en_d = fu_en_q;  fu_rx_d = fu_rx_q;  fu_ry_d = fu_ry_q;
    fu_op_d = fu_op_q;  fu_label_d = fu_label_q;
    res_valid_d = res_valid_q;  res_tag_d = res_tag_q;  res_data_d = res_data_q;
`ifdef DIVZERO_TRAP_EN
    res_err_d = res_err_q;
`endif

    for (int unsigned i = 0; i < NUM_RS; i++) begin
      if (busy_q[IDX_W'(i)] && CdbValid) begin
        if (pj_q[IDX_W'(i)] && (CdbTag == qj_q[IDX_W'(i)])) begin
          pj_d[IDX_W'(i)] = 1'b0;
          vj_d[IDX_W'(i)] = CdbData;
        end
        if (pk_q[IDX_W'(i)] && (CdbTag == qk_q[IDX_W'(i)])) begin
          pk_d[IDX_W'(i)] = 1'b0;
          vk_d[IDX_W'(i)] = CdbData;
        end
      end
    end

    if (accept) begin
      busy_d[free_idx] = 1'b1;
      disp_d[free_idx] = 1'b0;
      op_d[free_idx]   = IssueOp;
      qj_d[free_idx]   = IssueQj;
      qk_d[free_idx]   = IssueQk;
      pj_d[free_idx]   = IssueQjValid && !(CdbValid && (CdbTag == IssueQj));
      pk_d[free_idx]   = IssueQkValid && !(CdbValid && (CdbTag == IssueQk));
      vj_d[free_idx]   = (IssueQjValid && CdbValid && (CdbTag == IssueQj)) ? CdbData : IssueVj;
      vk_d[free_idx]   = (IssueQkValid && CdbValid && (CdbTag == IssueQk)) ? CdbData : IssueVk;
    end

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          disp_d[pick_idx] = 1'b1;
          cur_d            = pick_idx;
          last_d           = pick_idx;
`ifdef DIVZERO_TRAP_EN
          if ((op_q[pick_idx] == OP_DIV) && (vk_q[pick_idx] == '0)) begin
            res_valid_d = 1'b1;
            res_tag_d   = TAG_W'(TAG_BASE) + TAG_W'(pick_idx);
            res_data_d  = '1;
            res_err_d   = 1'b1;
            state_d     = S_RESULT;
          end else begin
`else
          begin
`endif
            fu_en_d    = 1'b1;
            fu_rx_d    = vj_q[pick_idx];
            fu_ry_d    = vk_q[pick_idx];
            fu_op_d    = op_q[pick_idx];
            fu_label_d = TAG_W'(TAG_BASE) + TAG_W'(pick_idx);
            state_d    = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (FuDone && (FuLabelOut == fu_label_q)) begin
          res_valid_d = 1'b1;
          res_tag_d   = fu_label_q;
          res_data_d  = FuOut;
          fu_en_d     = 1'b0;
          state_d     = S_RESULT;
        end
      end
      S_RESULT: begin
        if (ResAck) begin
          busy_d[cur_q] = 1'b0;
          disp_d[cur_q] = 1'b0;
          res_valid_d   = 1'b0;
`ifdef DIVZERO_TRAP_EN
          res_err_d     = 1'b0;
`endif
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = ~&busy_d;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      busy_q <= '0;  disp_q <= '0;  pj_q <= '0;  pk_q <= '0;
      vj_q <= '{default: '0};  vk_q <= '{default: '0};
      qj_q <= '{default: '0};  qk_q <= '{default: '0};
      op_q <= '{default: '0};
      cur_q <= '0;  last_q <= IDX_W'(NUM_RS - 1);
      ready_q <= 1'b0;
      fu_en_q <= 1'b0;  fu_rx_q <= '0;  fu_ry_q <= '0;  fu_op_q <= '0;  fu_label_q <= '0;
      res_valid_q <= 1'b0;  res_tag_q <= '0;  res_data_q <= '0;
`ifdef DIVZERO_TRAP_EN
      res_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;  disp_q <= disp_d;  pj_q <= pj_d;  pk_q <= pk_d;
      vj_q <= vj_d;  vk_q <= vk_d;  qj_q <= qj_d;  qk_q <= qk_d;  op_q <= op_d;
      cur_q <= cur_d;  last_q <= last_d;
      ready_q <= ready_d;
      fu_en_q <= fu_en_d;  fu_rx_q <= fu_rx_d;  fu_ry_q <= fu_ry_d;
      fu_op_q <= fu_op_d;  fu_label_q <= fu_label_d;
      res_valid_q <= res_valid_d;  res_tag_q <= res_tag_d;  res_data_q <= res_data_d;
`ifdef DIVZERO_TRAP_EN
      res_err_q <= res_err_d;
`endif
    end
  end

  assign FuEn     = fu_en_q;
  assign FuRx     = fu_rx_q;
  assign FuRy     = fu_ry_q;
  assign FuOp     = fu_op_q;
  assign FuLabel  = fu_label_q;
  assign ResValid = res_valid_q;
  assign ResTag   = res_tag_q;
  assign ResData  = res_data_q;
`ifdef DIVZERO_TRAP_EN
  assign ResErr   = res_err_q;
`endif

endmodule

// File: tb/tb_muldiv_rs_scheduler.sv
// Directed bench for muldiv_rs_scheduler with a small 2-cycle MUL/DIV unit model.
module tb_muldiv_rs_scheduler;

  logic        Clock = 1'b0;
  logic        Reset, IssueValid, IssueQjValid, IssueQkValid;
  logic [2:0]  IssueOp;
  logic [11:0] IssueVj, IssueVk;
  logic [1:0]  IssueQj, IssueQk;
  logic        IssueReady, IssueIllegal;
  logic [1:0]  IssueTag;
  logic        CdbValid;
  logic [1:0]  CdbTag;
  logic [11:0] CdbData;
  logic        FuEn;
  logic [11:0] FuRx, FuRy;
  logic [2:0]  FuOp;
  logic [1:0]  FuLabel;
  logic        FuDone = 1'b0;
  logic [11:0] FuOut = '0;
  logic [1:0]  FuLabelOut = '0;
  logic        ResValid, ResAck;
  logic [1:0]  ResTag;
  logic [11:0] ResData;
`ifdef DIVZERO_TRAP_EN
  logic        ResErr;
`endif

  int vectors = 0;
  int miscompares = 0;
  int unsigned fu_cnt = 0;

  muldiv_rs_scheduler #(.DATA_W(12), .NUM_RS(2), .TAG_W(2), .TAG_BASE(2)) dut (
    .Clock(Clock), .Reset(Reset),
    .IssueValid(IssueValid), .IssueOp(IssueOp), .IssueVj(IssueVj), .IssueVk(IssueVk),
    .IssueQj(IssueQj), .IssueQk(IssueQk), .IssueQjValid(IssueQjValid), .IssueQkValid(IssueQkValid),
    .IssueReady(IssueReady), .IssueTag(IssueTag), .IssueIllegal(IssueIllegal),
    .CdbValid(CdbValid), .CdbTag(CdbTag), .CdbData(CdbData),
    .FuEn(FuEn), .FuRx(FuRx), .FuRy(FuRy), .FuOp(FuOp), .FuLabel(FuLabel),
    .FuDone(FuDone), .FuOut(FuOut), .FuLabelOut(FuLabelOut),
    .ResValid(ResValid), .ResTag(ResTag), .ResData(ResData),
`ifdef DIVZERO_TRAP_EN
    .ResErr(ResErr),
`endif
    .ResAck(ResAck)
  );

  always #5 Clock = ~Clock;

  // FU model: Done two edges after FuEn rises, cleared whenever FuEn drops.
  always @(posedge Clock) begin
    if (FuEn !== 1'b1) begin
      fu_cnt <= 0;
      FuDone <= 1'b0;
    end else begin
      if (fu_cnt < 2) fu_cnt <= fu_cnt + 1;
      FuDone     <= (fu_cnt >= 1);
      FuLabelOut <= FuLabel;
      if (FuOp == 3'b010) FuOut <= 12'(FuRx * FuRy);
      else                FuOut <= (FuRy == '0) ? 12'hFFF : FuRx / FuRy;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [11:0] vj, input logic [11:0] vk,
                       input logic qjv, input logic [1:0] qj, input logic qkv, input logic [1:0] qk);
    IssueValid = 1'b1;  IssueOp = op;  IssueVj = vj;  IssueVk = vk;
    IssueQjValid = qjv; IssueQj = qj;  IssueQkValid = qkv; IssueQk = qk;
  endtask

  task automatic idle_issue();
    IssueValid = 1'b0;  IssueOp = '0;  IssueQjValid = 1'b0;  IssueQkValid = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (ResValid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_resvalid"}, 32'(ResValid), 32'd1);
  endtask

  task automatic ack();
    ResAck = 1'b1;
    tick();
    ResAck = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;  ResAck = 1'b0;  CdbValid = 1'b0;  CdbTag = '0;  CdbData = '0;
    IssueVj = '0;  IssueVk = '0;  IssueQj = '0;  IssueQk = '0;
    idle_issue();
    tick();
    tick();
    chk("rst_ready", 32'(IssueReady), 32'd0);
    chk("rst_fuen", 32'(FuEn), 32'd0);
    chk("rst_resvalid", 32'(ResValid), 32'd0);
    chk("rst_tag", 32'(IssueTag), 32'd0);
    Reset = 1'b0;
    tick();
    chk("post_rst_ready", 32'(IssueReady), 32'd1);

    // 1: single ready MUL 3*5
    issue(3'b010, 12'd3, 12'd5, 1'b0, 2'd0, 1'b0, 2'd0);
    #1;
    chk("t1_issuetag", 32'(IssueTag), 32'd2);
    chk("t1_illegal", 32'(IssueIllegal), 32'd0);
    tick();
    idle_issue();
    chk("t1_fuen_wait", 32'(FuEn), 32'd0);
    tick();
    chk("t1_fuen", 32'(FuEn), 32'd1);
    chk("t1_furx", 32'(FuRx), 32'd3);
    chk("t1_fury", 32'(FuRy), 32'd5);
    chk("t1_fuop", 32'(FuOp), 32'd2);
    chk("t1_fulabel", 32'(FuLabel), 32'd2);
    wait_res("t1");
    chk("t1_resdata", 32'(ResData), 32'd15);
    chk("t1_restag", 32'(ResTag), 32'd2);
    chk("t1_fuen_off", 32'(FuEn), 32'd0);
    ack();
    chk("t1_resvalid_off", 32'(ResValid), 32'd0);

    // 2: fill both stations, third issue refused
    issue(3'b010, 12'd2, 12'd3, 1'b0, 2'd0, 1'b0, 2'd0);
    #1;
    chk("t2_tag_a", 32'(IssueTag), 32'd2);
    tick();
    issue(3'b010, 12'd4, 12'd5, 1'b0, 2'd0, 1'b0, 2'd0);
    #1;
    chk("t2_tag_b", 32'(IssueTag), 32'd3);
    tick();
    chk("t2_full", 32'(IssueReady), 32'd0);
    issue(3'b010, 12'd7, 12'd7, 1'b0, 2'd0, 1'b0, 2'd0);
    #1;
    chk("t2_full_illegal", 32'(IssueIllegal), 32'd0);
    tick();
    idle_issue();
    wait_res("t2a");
    chk("t2a_restag", 32'(ResTag), 32'd2);
    chk("t2a_resdata", 32'(ResData), 32'd6);
    ack();
    chk("t2_freed_ready", 32'(IssueReady), 32'd1);
    chk("t2_freed_tag", 32'(IssueTag), 32'd2);
    wait_res("t2b");
    chk("t2b_restag", 32'(ResTag), 32'd3);
    chk("t2b_resdata", 32'(ResData), 32'd20);
    ack();
    repeat (8) tick();
    chk("t2_no_third_fuen", 32'(FuEn), 32'd0);
    chk("t2_no_third_res", 32'(ResValid), 32'd0);

    // 3: DIV waiting on tag 1 for Vj, woken by CDB
    issue(3'b011, 12'd0, 12'd4, 1'b1, 2'd1, 1'b0, 2'd0);
    #1;
    chk("t3_issuetag", 32'(IssueTag), 32'd2);
    tick();
    idle_issue();
    repeat (3) tick();
    chk("t3_pending_fuen", 32'(FuEn), 32'd0);
    CdbValid = 1'b1;  CdbTag = 2'd1;  CdbData = 12'd100;
    tick();
    CdbValid = 1'b0;
    wait_res("t3");
    chk("t3_resdata", 32'(ResData), 32'd25);
    chk("t3_restag", 32'(ResTag), 32'd2);
    ack();

    // 4: Qk forwarded from CDB in the issue cycle
    issue(3'b010, 12'd6, 12'd0, 1'b0, 2'd0, 1'b1, 2'd1);
    CdbValid = 1'b1;  CdbTag = 2'd1;  CdbData = 12'd7;
    #1;
    chk("t4_issuetag", 32'(IssueTag), 32'd2);
    tick();
    idle_issue();
    CdbValid = 1'b0;
    wait_res("t4");
    chk("t4_resdata", 32'(ResData), 32'd42);
    ack();

    // 5b: both stations woken together; last dispatch was station 0, so station 1 goes first
    issue(3'b010, 12'd0, 12'd5, 1'b1, 2'd1, 1'b0, 2'd0);
    tick();
    issue(3'b010, 12'd0, 12'd7, 1'b1, 2'd1, 1'b0, 2'd0);
    tick();
    idle_issue();
    repeat (2) tick();
    chk("t5b_pending_fuen", 32'(FuEn), 32'd0);
    CdbValid = 1'b1;  CdbTag = 2'd1;  CdbData = 12'd3;
    tick();
    CdbValid = 1'b0;
    wait_res("t5b_first");
    chk("t5b_first_tag", 32'(ResTag), 32'd3);
    chk("t5b_first_data", 32'(ResData), 32'd21);
    ack();
    wait_res("t5b_second");
    chk("t5b_second_tag", 32'(ResTag), 32'd2);
    chk("t5b_second_data", 32'(ResData), 32'd15);
    ack();

    // 5a: two ready ops, first result held while ResAck is withheld
    issue(3'b010, 12'd2, 12'd2, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    issue(3'b010, 12'd3, 12'd3, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    idle_issue();
    wait_res("t5a_first");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5a_hold_valid", 32'(ResValid), 32'd1);
      chk("t5a_hold_data", 32'(ResData), 32'd4);
      chk("t5a_hold_tag", 32'(ResTag), 32'd2);
      chk("t5a_hold_fuen", 32'(FuEn), 32'd0);
    end
    ack();
    wait_res("t5a_second");
    chk("t5a_second_tag", 32'(ResTag), 32'd3);
    chk("t5a_second_data", 32'(ResData), 32'd9);
    ack();

    // Illegal opcode: pulse, no allocation
    issue(3'b101, 12'd1, 12'd1, 1'b0, 2'd0, 1'b0, 2'd0);
    #1;
    chk("ill_pulse", 32'(IssueIllegal), 32'd1);
    tick();
    idle_issue();
    #1;
    chk("ill_pulse_end", 32'(IssueIllegal), 32'd0);
    chk("ill_no_alloc_tag", 32'(IssueTag), 32'd2);
    repeat (4) tick();
    chk("ill_no_fuen", 32'(FuEn), 32'd0);

    // 6: reset while the FU is busy
    issue(3'b010, 12'd2, 12'd2, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    idle_issue();
    tick();
    chk("t6_busy_fuen", 32'(FuEn), 32'd1);
    Reset = 1'b1;
    tick();
    chk("t6_rst_fuen", 32'(FuEn), 32'd0);
    chk("t6_rst_resvalid", 32'(ResValid), 32'd0);
    Reset = 1'b0;
    tick();
    chk("t6_ready", 32'(IssueReady), 32'd1);
    chk("t6_tag", 32'(IssueTag), 32'd2);
    repeat (6) tick();
    chk("t6_dropped_res", 32'(ResValid), 32'd0);
    chk("t6_dropped_fuen", 32'(FuEn), 32'd0);

`ifdef DIVZERO_TRAP_EN
    issue(3'b011, 12'd9, 12'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    idle_issue();
    wait_res("dz");
    chk("dz_resdata", 32'(ResData), 32'hFFF);
    chk("dz_reserr", 32'(ResErr), 32'd1);
    chk("dz_restag", 32'(ResTag), 32'd2);
    chk("dz_fuen", 32'(FuEn), 32'd0);
    ack();
    chk("dz_reserr_clr", 32'(ResErr), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
